fetch_stage_ctrl: RTL and testbench

- IF stage of the 5-stage RISC-V pipeline.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- It is the consumer of the hazard unit's stall indication and of the ID-stage branch flush.
- It holds the PC and IF/ID on stall, injects NOP bubbles on flush or memory wait, and buffers a fetched instruction that returns while the pipe is stalled.

---
 rtl/fetch_stage_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl.sv
// rtl/fetch_stage_ctrl.sv - IF stage: PC register, imem request handshake, IF/ID register (optional FETCH_PERF_CNT_EN counters)
module fetch_stage_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            Stall_i,
  input  logic            Flush_i,
  input  logic [XLEN-1:0] BranchAddr_i,
  output logic            Imem_Req_o,
  output logic [XLEN-1:0] Imem_Addr_o,
  input  logic            Imem_Ack_i,
  input  logic [31:0]     Imem_Data_i,
  output logic [XLEN-1:0] PC_o,
  output logic [XLEN-1:0] IFID_PC_o,
  output logic [31:0]     IFID_Instr_o,
  output logic            IFID_Valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     FetchCnt_o,
  output logic [31:0]     BubbleCnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state_q, state_next;

  logic [XLEN-1:0] pc_q, pc_next, pc_plus4;
  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] ifid_pc_q;
  logic [31:0]     ifid_instr_q;
  logic            ifid_valid_q;
  logic [XLEN-1:0] buf_pc_q;
  logic [31:0]     buf_instr_q;

  logic ifid_ld_mem;
  logic ifid_ld_buf;
  logic ifid_ld_bubble;
  logic buf_ld;

  assign pc_plus4 = pc_q + XLEN'(4);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (Flush_i) begin
          state_next = Imem_Ack_i ? FETCH : DRAIN;
        end else if (Stall_i && Imem_Ack_i) begin
          state_next = HOLD;
        end
      end
      DRAIN: begin
        if (Imem_Ack_i) begin
          state_next = FETCH;
        end
      end
      HOLD: begin
        if (Flush_i || !Stall_i) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath controls; acks outside FETCH/DRAIN are never looked at.
  always_comb begin
    Imem_Req_o     = 1'b0;
    pc_next        = pc_q;
    ifid_ld_mem    = 1'b0;
    ifid_ld_buf    = 1'b0;
    ifid_ld_bubble = 1'b0;
    buf_ld         = 1'b0;
    case (state_q)
      IDLE: begin
        if (Flush_i) begin
          pc_next        = BranchAddr_i;
          ifid_ld_bubble = 1'b1;
        end else if (!Stall_i) begin
          ifid_ld_bubble = 1'b1;
        end
      end
      FETCH: begin
        Imem_Req_o = 1'b1;
        if (Flush_i) begin
          pc_next        = BranchAddr_i;
          ifid_ld_bubble = 1'b1;
        end else if (Stall_i) begin
          buf_ld = Imem_Ack_i;
        end else if (Imem_Ack_i) begin
          pc_next     = pc_plus4;
          ifid_ld_mem = 1'b1;
        end else begin
          ifid_ld_bubble = 1'b1;
        end
      end
      DRAIN: begin
        Imem_Req_o = 1'b1;
        if (Flush_i) begin
          pc_next = BranchAddr_i;
        end
        ifid_ld_bubble = Flush_i || !Stall_i;
      end
      HOLD: begin
        if (Flush_i) begin
          pc_next        = BranchAddr_i;
          ifid_ld_bubble = 1'b1;
        end else if (!Stall_i) begin
          pc_next     = pc_plus4;
          ifid_ld_buf = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // req_addr only moves when a fresh request begins, so it is frozen across DRAIN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      buf_pc_q     <= '0;
      buf_instr_q  <= NOP_INSTR;
    end else begin
      pc_q <= pc_next;
      if (state_next == FETCH) begin
        req_addr_q <= pc_next;
      end
      if (buf_ld) begin
        buf_pc_q    <= pc_q;
        buf_instr_q <= Imem_Data_i;
      end
      if (ifid_ld_mem) begin
        ifid_pc_q    <= pc_q;
        ifid_instr_q <= Imem_Data_i;
        ifid_valid_q <= 1'b1;
      end else if (ifid_ld_buf) begin
        ifid_pc_q    <= buf_pc_q;
        ifid_instr_q <= buf_instr_q;
        ifid_valid_q <= 1'b1;
      end else if (ifid_ld_bubble) begin
        ifid_instr_q <= NOP_INSTR;
        ifid_valid_q <= 1'b0;
      end
    end
  end

  assign Imem_Addr_o  = req_addr_q;
  assign PC_o         = pc_q;
  assign IFID_PC_o    = ifid_pc_q;
  assign IFID_Instr_o = ifid_instr_q;
  assign IFID_Valid_o = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if ((ifid_ld_mem || ifid_ld_buf) && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (ifid_ld_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign FetchCnt_o  = fetch_cnt_q;
  assign BubbleCnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb/tb_fetch_stage_ctrl.sv - directed self-checking bench for fetch_stage_ctrl
module tb_fetch_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] baddr;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [31:0] pc;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        auto_ack;
  logic        ack_man;
  int          tests;
  int          fails;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign ack  = auto_ack ? req : ack_man;
  assign data = mem_word(addr);

  fetch_stage_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .Stall_i      (stall),
    .Flush_i      (flush),
    .BranchAddr_i (baddr),
    .Imem_Req_o   (req),
    .Imem_Addr_o  (addr),
    .Imem_Ack_i   (ack),
    .Imem_Data_i  (data),
    .PC_o         (pc),
    .IFID_PC_o    (ifid_pc),
    .IFID_Instr_o (ifid_instr),
    .IFID_Valid_o (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCnt_o   (fetch_cnt),
    .BubbleCnt_o  (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    baddr    = 32'h0;
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
    tests++; if (ifid_pc !== 32'h0) begin fails++; $display("FAIL rst_ifid_pc got=%h exp=%h", ifid_pc, 32'h0); end
    tests++; if (ifid_instr !== NOP) begin fails++; $display("FAIL rst_instr got=%h exp=%h", ifid_instr, NOP); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", ifid_valid); end
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL rst_req got=%b exp=0", req); end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_reset();
    auto_ack = 1'b1;
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL zw_idle_req got=%b exp=0", req); end
    tick();
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL zw_first_bubble got=%b exp=0", ifid_valid); end
    tests++; if (req !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL zw_first_req got=%b/%h exp=1/%h", req, addr, 32'h0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (ifid_pc !== 32'(4 * i) || ifid_valid !== 1'b1 || ifid_instr !== mem_word(32'(4 * i))) begin
        fails++;
        $display("FAIL zw_ifid%0d got=%h/%b/%h exp=%h/1/%h", i, ifid_pc, ifid_valid, ifid_instr, 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
    tests++; if (pc !== 32'h10) begin fails++; $display("FAIL zw_pc got=%h exp=%h", pc, 32'h10); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    auto_ack = 1'b1;
    tick();
    tick();
    tick();
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== 32'h4) begin
        fails++;
        $display("FAIL mw_bubble%0d got=%h/%b/%h exp=%h/0/%h", i, ifid_pc, ifid_valid, ifid_instr, 32'h4, NOP);
      end
      tests++; if (req !== 1'b1 || addr !== 32'h8) begin fails++; $display("FAIL mw_addr%0d got=%b/%h exp=1/%h", i, req, addr, 32'h8); end
    end
    ack_man = 1'b1;
    tick();
    ack_man  = 1'b0;
    auto_ack = 1'b1;
    tests++;
    if (ifid_pc !== 32'h8 || ifid_valid !== 1'b1 || ifid_instr !== mem_word(32'h8)) begin
      fails++;
      $display("FAIL mw_deliver got=%h/%b/%h exp=%h/1/%h", ifid_pc, ifid_valid, ifid_instr, 32'h8, mem_word(32'h8));
    end
    tests++; if (pc !== 32'hC) begin fails++; $display("FAIL mw_pc got=%h exp=%h", pc, 32'hC); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (ifid_pc !== 32'h8 || ifid_valid !== 1'b1 || ifid_instr !== mem_word(32'h8)) begin
        fails++;
        $display("FAIL st_hold%0d got=%h/%b/%h exp=%h/1/%h", i, ifid_pc, ifid_valid, ifid_instr, 32'h8, mem_word(32'h8));
      end
      tests++; if (req !== 1'b0 || pc !== 32'hC) begin fails++; $display("FAIL st_req%0d got=%b/%h exp=0/%h", i, req, pc, 32'hC); end
    end
    stall = 1'b0;
    tick();
    tests++;
    if (ifid_pc !== 32'hC || ifid_valid !== 1'b1 || ifid_instr !== mem_word(32'hC)) begin
      fails++;
      $display("FAIL st_release got=%h/%b/%h exp=%h/1/%h", ifid_pc, ifid_valid, ifid_instr, 32'hC, mem_word(32'hC));
    end
    tests++; if (req !== 1'b1 || addr !== 32'h10) begin fails++; $display("FAIL st_next_req got=%b/%h exp=1/%h", req, addr, 32'h10); end
  endtask

  task automatic test_flush_drain();
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    tests++; if (addr !== 32'h14) begin fails++; $display("FAIL fd_pre_addr got=%h exp=%h", addr, 32'h14); end
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    flush    = 1'b1;
    baddr    = 32'h100;
    tick();
    flush = 1'b0;
    tests++; if (pc !== 32'h100) begin fails++; $display("FAIL fd_pc got=%h exp=%h", pc, 32'h100); end
    tests++; if (req !== 1'b1 || addr !== 32'h14) begin fails++; $display("FAIL fd_drain_addr got=%b/%h exp=1/%h", req, addr, 32'h14); end
    tests++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin fails++; $display("FAIL fd_bubble0 got=%b/%h exp=0/%h", ifid_valid, ifid_instr, NOP); end
    tick();
    tests++; if (ifid_valid !== 1'b0 || addr !== 32'h14) begin fails++; $display("FAIL fd_bubble1 got=%b/%h exp=0/%h", ifid_valid, addr, 32'h14); end
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    tests++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin fails++; $display("FAIL fd_discard got=%b/%h exp=0/%h", ifid_valid, ifid_instr, NOP); end
    tests++; if (req !== 1'b1 || addr !== 32'h100) begin fails++; $display("FAIL fd_new_req got=%b/%h exp=1/%h", req, addr, 32'h100); end
    auto_ack = 1'b1;
    tick();
    tests++;
    if (ifid_pc !== 32'h100 || ifid_valid !== 1'b1 || ifid_instr !== mem_word(32'h100)) begin
      fails++;
      $display("FAIL fd_deliver got=%h/%b/%h exp=%h/1/%h", ifid_pc, ifid_valid, ifid_instr, 32'h100, mem_word(32'h100));
    end
  endtask

  task automatic test_flush_in_hold();
    do_reset();
    auto_ack = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    tick();
    tests++; if (req !== 1'b0 || pc !== 32'h4) begin fails++; $display("FAIL fh_hold got=%b/%h exp=0/%h", req, pc, 32'h4); end
    flush = 1'b1;
    baddr = 32'h200;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    tests++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin fails++; $display("FAIL fh_bubble got=%b/%h exp=0/%h", ifid_valid, ifid_instr, NOP); end
    tests++; if (pc !== 32'h200 || addr !== 32'h200) begin fails++; $display("FAIL fh_pc got=%h/%h exp=%h", pc, addr, 32'h200); end
    tick();
    tests++; if (ifid_pc !== 32'h200 || ifid_valid !== 1'b1) begin fails++; $display("FAIL fh_next got=%h/%b exp=%h/1", ifid_pc, ifid_valid, 32'h200); end
  endtask

  task automatic test_wrap();
    do_reset();
    auto_ack = 1'b1;
    tick();
    flush = 1'b1;
    baddr = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    tests++; if (pc !== 32'hFFFF_FFFC || addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wr_redirect got=%h/%h exp=%h", pc, addr, 32'hFFFF_FFFC); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL wr_bubble got=%b exp=0", ifid_valid); end
    tick();
    tests++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_valid !== 1'b1) begin fails++; $display("FAIL wr_ifid got=%h/%b exp=%h/1", ifid_pc, ifid_valid, 32'hFFFF_FFFC); end
    tests++; if (pc !== 32'h0 || addr !== 32'h0) begin fails++; $display("FAIL wr_pc got=%h/%h exp=%h", pc, addr, 32'h0); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    auto_ack = 1'b1;
    tick();
    tick();
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    flush    = 1'b1;
    baddr    = 32'h300;
    tick();
    flush = 1'b0;
    tests++; if (pc !== 32'h300 || req !== 1'b1) begin fails++; $display("FAIL rd_drain got=%h/%b exp=%h/1", pc, req, 32'h300); end
    rst = 1'b1;
    #1;
    tests++; if (pc !== 32'h0 || ifid_pc !== 32'h0) begin fails++; $display("FAIL rd_async_pc got=%h/%h exp=0/0", pc, ifid_pc); end
    tests++; if (ifid_instr !== NOP || ifid_valid !== 1'b0 || req !== 1'b0) begin fails++; $display("FAIL rd_async_ifid got=%h/%b/%b exp=%h/0/0", ifid_instr, ifid_valid, req, NOP); end
    tick();
    rst     = 1'b0;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    tests++; if (ifid_valid !== 1'b0 || pc !== 32'h0) begin fails++; $display("FAIL rd_late_ack got=%b/%h exp=0/%h", ifid_valid, pc, 32'h0); end
    tests++; if (req !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL rd_req got=%b/%h exp=1/%h", req, addr, 32'h0); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst      = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    baddr    = 32'h0;
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    test_reset();
    test_zero_wait();
    test_mem_wait();
    test_stall_hold();
    test_flush_drain();
    test_flush_in_hold();
    test_wrap();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
